aes_cipher_unit: RTL and testbench
==================================

Name: aes_cipher_unit

Overview:
- Iterative AES (FIPS-197) engine: encrypts or decrypts 128-bit blocks with 128/192/256-bit keys, one round per clock.
- Contains an internal round-key expansion store, a sequencer FSM, and a shared round datapath (SubBytes/ShiftRows/MixColumns/AddRoundKey and their inverses).
- Sits behind a bus wrapper that supplies the key, block and mode.

Parameters:
- none; the key-length mode is runtime-selected via KL.

Ports:
- CLK  in  1  clock, rising edge.
- CLR  in  1  reset; asynchronous, active-high. Clears all state.
- CK  in  1  synchronous key reload; high = latch KEY/KL, clear round keys, abort current block.
- KEY  in  8x32  key words; KEY[0] = first 4 key bytes, MSB first. 128-bit uses [0..3], 192-bit uses [0..5], 256-bit uses [0..7].
- KL  in  2  key length: 0 = 128-bit (Nr=10), 1 = 192-bit (Nr=12), 2 = 256-bit (Nr=14), 3 = treated as 0.
- enc_dec  in  1  1 = encrypt, 0 = decrypt; sampled at block load.
- state_i  in  4x32  input block. state_i[c] is column c; bits [31:24] = row 0. state_i[0] = first 4 block bytes.
- state_o  out  4x32  result block, same packing as state_i; registered.
- CF  out  1  cipher-finished; one-cycle pulse when state_o is updated.

Behaviour:
- CLR=1 (async): FSM -> KLOAD; state_o=0, CF=0; all round keys, key registers and round counter = 0.
- States: KLOAD -> KEXP -> LOAD -> ROUND -> LOAD ... (continuous).
- KLOAD: taken on every cycle with CK=1 (and after CLR).
  - Latch KEY words and KL; Nk = 4/6/8; round-key words w[0..Nk-1] = KEY.
  - Leave to KEXP on the first cycle with CK=0 and CLR=0.
- KEXP: generate 4 new w words per cycle with the standard recurrence: RotWord/SubWord/Rcon every Nk words; extra SubWord at i mod 8 = 4 for Nk=8.
  - Completes when 4*(Nr+1) words exist (44/52/60), i.e. 10/12/13 cycles, then -> LOAD.
  - CF=0 throughout (stall).
- LOAD (1 cycle): sample state_i and enc_dec.
  - Encrypt: s = state_i ^ rk[0].
  - Decrypt: s = state_i ^ rk[Nr].
  - Round counter R = 1.
- ROUND (Nr cycles, R = 1..Nr):
  - Encrypt: s = MixColumns(ShiftRows(SubBytes(s))) ^ rk[R]; MixColumns is skipped when R=Nr.
  - Decrypt: s = InvMixColumns(InvSubBytes(InvShiftRows(s)) ^ rk[Nr-R]); InvMixColumns is skipped when R=Nr.
  - At R=Nr: state_o <= result, CF=1 for the following cycle, FSM -> LOAD.
- Latency: AES-128 block = 1 load cycle + 10 rounds; state_o/CF change 11 cycles after the LOAD edge. AES-192: 13 cycles; AES-256: 15 cycles.
- After reset/CK, the first CF is at KEXP + 11/13/15 cycles.
- state_o holds its value until the next completion. CF is never high for two consecutive cycles.
- state_i/enc_dec changes outside the LOAD cycle do not affect the block in flight.
- KL/KEY changes without CK are ignored.
- CK=1 mid-block: block discarded, no CF, state_o unchanged, restart at KLOAD.
- CK and CLR both high: CLR wins.
- Mode change between blocks via enc_dec takes effect at the next LOAD.

Decomposition:
- Package aes_pkg:
  - SBOX and INV_SBOX constant arrays; RCON array.
  - Functions: xtime, gf_mul, sub_word, rot_word, mix_col, inv_mix_col.
  - Typedef state_t (4x32); Nr/Nk lookup from KL.
- Sub-module: aes_key_expand — key registers, word store, KEXP counter, done flag.
- Round datapath and sequencer FSM stay in aes_cipher_unit.

Test Plan:
- AES-128 encrypt.
  - Stimulus: KL=0; KEY[0..3] = 54686174, 73206D79, 204B756E, 67204675; enc_dec=1; state_i[0..3] = 54776F20, 4F6E6520, 4E696E65, 2054776F; CLR 1 cycle, CK 1 cycle.
  - Required: CF=0 during the 10-cycle expansion; first CF 11 cycles after LOAD with state_o[0..3] = 29C3505F, 571420F6, 402299B3, 1A02D73A.
- AES-128 decrypt, same key: enc_dec=0, state_i = that ciphertext -> state_o = the plaintext above. Also continuous back-to-back enc then dec with an enc_dec switch between blocks.
- AES-192.
  - Stimulus: KL=1; KEY = 00010203 .. 14151617; state_i = 00112233, 44556677, 8899AABB, CCDDEEFF; encrypt.
  - Required: state_o = DDA97CA4, 864CDFE0, 6EAF70A0, EC0D7191 after 13 cycles.
  - Decrypt returns the plaintext.
- AES-256.
  - Stimulus: KL=2; KEY = 00010203 .. 1C1D1E1F; same plaintext; encrypt.
  - Required: state_o = 8EA2B7CA, 516745BF, EAFC4990, 4B496089 after 15 cycles.
  - Decrypt returns the plaintext.
- Reset/abort.
  - CLR asserted mid-round -> immediately state_o=0, CF=0.
  - CK pulsed mid-block -> no CF for the aborted block; after re-expansion the correct ciphertext appears.
  - Changing state_i mid-block -> in-flight result unaffected.
- KL=3 with the AES-128 key -> same result as KL=0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers, block type and key-length lookups.
package aes_pkg;

   typedef logic [3:0][31:0] state_t;

   typedef enum logic [1:0] {S_KLOAD, S_KEXP, S_LOAD, S_ROUND} fsm_e;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16};

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52,8'h09,8'h6a,8'hd5,8'h30,8'h36,8'ha5,8'h38,8'hbf,8'h40,8'ha3,8'h9e,8'h81,8'hf3,8'hd7,8'hfb,
      8'h7c,8'he3,8'h39,8'h82,8'h9b,8'h2f,8'hff,8'h87,8'h34,8'h8e,8'h43,8'h44,8'hc4,8'hde,8'he9,8'hcb,
      8'h54,8'h7b,8'h94,8'h32,8'ha6,8'hc2,8'h23,8'h3d,8'hee,8'h4c,8'h95,8'h0b,8'h42,8'hfa,8'hc3,8'h4e,
      8'h08,8'h2e,8'ha1,8'h66,8'h28,8'hd9,8'h24,8'hb2,8'h76,8'h5b,8'ha2,8'h49,8'h6d,8'h8b,8'hd1,8'h25,
      8'h72,8'hf8,8'hf6,8'h64,8'h86,8'h68,8'h98,8'h16,8'hd4,8'ha4,8'h5c,8'hcc,8'h5d,8'h65,8'hb6,8'h92,
      8'h6c,8'h70,8'h48,8'h50,8'hfd,8'hed,8'hb9,8'hda,8'h5e,8'h15,8'h46,8'h57,8'ha7,8'h8d,8'h9d,8'h84,
      8'h90,8'hd8,8'hab,8'h00,8'h8c,8'hbc,8'hd3,8'h0a,8'hf7,8'he4,8'h58,8'h05,8'hb8,8'hb3,8'h45,8'h06,
      8'hd0,8'h2c,8'h1e,8'h8f,8'hca,8'h3f,8'h0f,8'h02,8'hc1,8'haf,8'hbd,8'h03,8'h01,8'h13,8'h8a,8'h6b,
      8'h3a,8'h91,8'h11,8'h41,8'h4f,8'h67,8'hdc,8'hea,8'h97,8'hf2,8'hcf,8'hce,8'hf0,8'hb4,8'he6,8'h73,
      8'h96,8'hac,8'h74,8'h22,8'he7,8'had,8'h35,8'h85,8'he2,8'hf9,8'h37,8'he8,8'h1c,8'h75,8'hdf,8'h6e,
      8'h47,8'hf1,8'h1a,8'h71,8'h1d,8'h29,8'hc5,8'h89,8'h6f,8'hb7,8'h62,8'h0e,8'haa,8'h18,8'hbe,8'h1b,
      8'hfc,8'h56,8'h3e,8'h4b,8'hc6,8'hd2,8'h79,8'h20,8'h9a,8'hdb,8'hc0,8'hfe,8'h78,8'hcd,8'h5a,8'hf4,
      8'h1f,8'hdd,8'ha8,8'h33,8'h88,8'h07,8'hc7,8'h31,8'hb1,8'h12,8'h10,8'h59,8'h27,8'h80,8'hec,8'h5f,
      8'h60,8'h51,8'h7f,8'ha9,8'h19,8'hb5,8'h4a,8'h0d,8'h2d,8'he5,8'h7a,8'h9f,8'h93,8'hc9,8'h9c,8'hef,
      8'ha0,8'he0,8'h3b,8'h4d,8'hae,8'h2a,8'hf5,8'hb0,8'hc8,8'heb,8'hbb,8'h3c,8'h83,8'h53,8'h99,8'h61,
      8'h17,8'h2b,8'h04,8'h7e,8'hba,8'h77,8'hd6,8'h26,8'he1,8'h69,8'h14,8'h63,8'h55,8'h21,8'h0c,8'h7d};

   // Entry 0 is unused; padded so any 4-bit index stays in range.
   localparam logic [7:0] RCON [16] = '{
      8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,
      8'h80,8'h1b,8'h36,8'h00,8'h00,8'h00,8'h00,8'h00};

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] inv_sub_word(input logic [31:0] w);
      return {INV_SBOX[w[31:24]], INV_SBOX[w[23:16]], INV_SBOX[w[15:8]], INV_SBOX[w[7:0]]};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'd2) ^ gf_mul(a1, 8'd3) ^ a2 ^ a3,
              a0 ^ gf_mul(a1, 8'd2) ^ gf_mul(a2, 8'd3) ^ a3,
              a0 ^ a1 ^ gf_mul(a2, 8'd2) ^ gf_mul(a3, 8'd3),
              gf_mul(a0, 8'd3) ^ a1 ^ a2 ^ gf_mul(a3, 8'd2)};
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = c;
      return {gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11) ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
              gf_mul(a0, 8'd9) ^ gf_mul(a1, 8'd14) ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
              gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9) ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
              gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13) ^ gf_mul(a2, 8'd9) ^ gf_mul(a3, 8'd14)};
   endfunction

   // KL=3 is folded into the 128-bit case.
   function automatic logic [3:0] kl_nr(input logic [1:0] kl);
      case (kl)
         2'd1:    return 4'd12;
         2'd2:    return 4'd14;
         default: return 4'd10;
      endcase
   endfunction

   function automatic logic [5:0] kl_nk(input logic [1:0] kl);
      case (kl)
         2'd1:    return 6'd6;
         2'd2:    return 6'd8;
         default: return 6'd4;
      endcase
   endfunction

endpackage

// File: rtl/aes_key_expand.sv
// Round-key word store: loads the cipher key, then expands four words per step.
module aes_key_expand
   import aes_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            load_i,
   input  logic            step_i,
   input  logic [7:0][31:0] key_i,
   input  logic [1:0]      kl_i,
   input  logic [3:0]      rk_idx_i,
   output state_t          rk_o,
   output logic [3:0]      nr_o,
   output logic            last_o
);

   logic [31:0] w_q [64];
   logic [5:0]  cnt_q;
   logic [1:0]  kl_q;
   logic [5:0]  nk, nk_in, nwords;
   logic [5:0]  widx [4];
   logic [31:0] new_w [4];
   logic [31:0] tmp;

   assign nk     = kl_nk(kl_q);
   assign nk_in  = kl_nk(kl_i);
   assign nr_o   = kl_nr(kl_q);
   assign nwords = {4'(nr_o + 4'd1), 2'b00};
   // 192-bit keys overshoot to 54 words on the last step; the extra words are never read.
   assign last_o = (cnt_q + 6'd4) >= nwords;

   // Next four schedule words, chained so each sees the word generated just before it.
   always_comb begin
      tmp = w_q[cnt_q - 6'd1];
      for (int k = 0; k < 4; k++) begin
         widx[k] = cnt_q + 6'(k);
         if ((widx[k] % nk) == 6'd0)
            tmp = sub_word(rot_word(tmp)) ^ {RCON[4'(widx[k] / nk)], 24'h0};
         else if (nk == 6'd8 && widx[k][2:0] == 3'd4)
            tmp = sub_word(tmp);
         new_w[k] = w_q[widx[k] - nk] ^ tmp;
         tmp      = new_w[k];
      end
   end

   // Round key R is words 4R..4R+3, word 4R+c forming column c.
   always_comb begin
      rk_o = '0;
      for (int c = 0; c < 4; c++)
         rk_o[c] = w_q[{rk_idx_i, 2'(c)}];
   end

   // Key load clears the whole store; each expansion step appends four words.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < 64; i++) w_q[i] <= '0;
         cnt_q <= '0;
         kl_q  <= '0;
      end else if (load_i) begin
         kl_q <= kl_i;
         for (int i = 0; i < 8; i++) w_q[i] <= (6'(i) < nk_in) ? key_i[i] : '0;
         for (int i = 8; i < 64; i++) w_q[i] <= '0;
         cnt_q <= nk_in;
      end else if (step_i) begin
         for (int k = 0; k < 4; k++) w_q[widx[k]] <= new_w[k];
         cnt_q <= cnt_q + 6'd4;
      end
   end

endmodule

// File: rtl/aes_cipher_unit.sv
// Iterative AES encrypt/decrypt engine, one round per clock.
//   state   | meaning
//   S_KLOAD | latch key/KL, wait for CK low
//   S_KEXP  | expand round keys, four words per cycle
//   S_LOAD  | sample block and direction, initial AddRoundKey
//   S_ROUND | one cipher round per cycle, R = 1..Nr
module aes_cipher_unit
   import aes_pkg::*;
(
   input  logic             CLK,
   input  logic             CLR,
   input  logic             CK,
   input  logic [7:0][31:0] KEY,
   input  logic [1:0]       KL,
   input  logic             enc_dec,
   input  state_t           state_i,
   output state_t           state_o,
   output logic             CF
);

   fsm_e       fsm_q, fsm_d;
   state_t     s_q, s_d, out_q, out_d, rk, rnd_res;
   state_t     e_sr, e_sub, e_res, d_sr, d_ark, d_res;
   logic       cf_q, cf_d, enc_q, enc_d, last_rnd, kx_last;
   logic [3:0] rnd_q, rnd_d, rk_idx, nr;

   aes_key_expand u_key (
      .clk_i    (CLK),
      .rst_i    (CLR),
      .load_i   (CK || fsm_q == S_KLOAD),
      .step_i   (!CK && fsm_q == S_KEXP),
      .key_i    (KEY),
      .kl_i     (KL),
      .rk_idx_i (rk_idx),
      .rk_o     (rk),
      .nr_o     (nr),
      .last_o   (kx_last)
   );

   assign last_rnd = (rnd_q == nr);
   assign state_o  = out_q;
   assign CF       = cf_q;

   // Round-key select: decryption walks the schedule backwards.
   always_comb begin
      rk_idx = enc_q ? rnd_q : nr - rnd_q;
      if (fsm_q == S_LOAD) rk_idx = enc_dec ? 4'd0 : nr;
   end

   // Shared round datapath for both directions.
   always_comb begin
      e_sr  = '0;
      d_sr  = '0;
      e_sub = '0;
      e_res = '0;
      d_ark = '0;
      d_res = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) begin
            e_sr[c][8*(3-r) +: 8] = s_q[(c+r)%4][8*(3-r) +: 8];
            d_sr[c][8*(3-r) +: 8] = s_q[(c+4-r)%4][8*(3-r) +: 8];
         end
      for (int c = 0; c < 4; c++) begin
         e_sub[c] = sub_word(e_sr[c]);
         e_res[c] = (last_rnd ? e_sub[c] : mix_col(e_sub[c])) ^ rk[c];
         d_ark[c] = inv_sub_word(d_sr[c]) ^ rk[c];
         d_res[c] = last_rnd ? d_ark[c] : inv_mix_col(d_ark[c]);
      end
      rnd_res = enc_q ? e_res : d_res;
   end

   // Sequencer next-state; CK overrides everything and drops the block in flight.
   always_comb begin
      fsm_d = fsm_q;
      s_d   = s_q;
      out_d = out_q;
      cf_d  = 1'b0;
      rnd_d = rnd_q;
      enc_d = enc_q;
      case (fsm_q)
         S_KLOAD: fsm_d = S_KEXP;
         S_KEXP:  if (kx_last) fsm_d = S_LOAD;
         S_LOAD: begin
            enc_d = enc_dec;
            s_d   = state_i ^ rk;
            rnd_d = 4'd1;
            fsm_d = S_ROUND;
         end
         S_ROUND: begin
            s_d   = rnd_res;
            rnd_d = rnd_q + 4'd1;
            if (last_rnd) begin
               out_d = rnd_res;
               cf_d  = 1'b1;
               fsm_d = S_LOAD;
            end
         end
         default: fsm_d = S_KLOAD;
      endcase
      if (CK) begin
         fsm_d = S_KLOAD;
         out_d = out_q;
         cf_d  = 1'b0;
         rnd_d = '0;
      end
   end

   // State registers.
   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         fsm_q <= S_KLOAD;
         s_q   <= '0;
         out_q <= '0;
         cf_q  <= 1'b0;
         rnd_q <= '0;
         enc_q <= 1'b0;
      end else begin
         fsm_q <= fsm_d;
         s_q   <= s_d;
         out_q <= out_d;
         cf_q  <= cf_d;
         rnd_q <= rnd_d;
         enc_q <= enc_d;
      end
   end

endmodule

// File: tb/tb_aes_cipher_unit.sv
// Directed bench for aes_cipher_unit using FIPS-197 / known-answer vectors.
module tb_aes_cipher_unit;
   import aes_pkg::*;

   logic             CLK;
   logic             CLR;
   logic             CK;
   logic [7:0][31:0] KEY;
   logic [1:0]       KL;
   logic             enc_dec;
   state_t           state_i;
   state_t           state_o;
   logic             CF;

   int checks   = 0;
   int failures = 0;

   string  tag_q [$];
   state_t data_q [$];
   int     lat_q [$];

   aes_cipher_unit dut (
      .CLK     (CLK),
      .CLR     (CLR),
      .CK      (CK),
      .KEY     (KEY),
      .KL      (KL),
      .enc_dec (enc_dec),
      .state_i (state_i),
      .state_o (state_o),
      .CF      (CF)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic state_t mk(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] c, input logic [31:0] d);
      state_t s;
      s[0] = a; s[1] = b; s[2] = c; s[3] = d;
      return s;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic expect_blk(input string tag, input state_t d, input int lat);
      tag_q.push_back(tag);
      data_q.push_back(d);
      lat_q.push_back(lat);
   endtask

   // Count falling edges until CF is seen (bounded), then score against the queue head.
   task automatic wait_cf();
      int     n;
      string  t;
      state_t d;
      int     l;
      n = 0;
      do begin
         @(negedge CLK);
         n++;
      end while (CF !== 1'b1 && n < 200);
      t = tag_q.pop_front();
      d = data_q.pop_front();
      l = lat_q.pop_front();
      check({t, "_latency"}, 128'(n), 128'(l));
      check({t, "_data"}, state_o, d);
   endtask

   task automatic pulse_ck();
      @(negedge CLK) CK = 1'b1;
      @(negedge CLK) CK = 1'b0;
   endtask

   state_t pt128, ct128, pt, ct192, ct256, junk;

   initial begin
      pt128 = mk(32'h54776F20, 32'h4F6E6520, 32'h4E696E65, 32'h2054776F);
      ct128 = mk(32'h29C3505F, 32'h571420F6, 32'h402299B3, 32'h1A02D73A);
      pt    = mk(32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF);
      ct192 = mk(32'hDDA97CA4, 32'h864CDFE0, 32'h6EAF70A0, 32'hEC0D7191);
      ct256 = mk(32'h8EA2B7CA, 32'h516745BF, 32'hEAFC4990, 32'h4B496089);
      junk  = mk(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D);

      CLR = 1'b1; CK = 1'b0; KEY = '0; KL = 2'd0; enc_dec = 1'b1; state_i = '0;
      @(negedge CLK);
      check("reset_state_o", state_o, '0);
      check("reset_cf", 128'(CF), 128'd0);

      // AES-128 encrypt from a fresh key load
      KEY[0] = 32'h54686174; KEY[1] = 32'h73206D79; KEY[2] = 32'h204B756E; KEY[3] = 32'h67204675;
      KL = 2'd0; enc_dec = 1'b1; state_i = pt128; CLR = 1'b0;
      pulse_ck();
      expect_blk("enc128", ct128, 22);
      wait_cf();

      // Back-to-back with direction switch
      enc_dec = 1'b0; state_i = ct128;
      expect_blk("dec128", pt128, 11);
      wait_cf();
      enc_dec = 1'b1; state_i = pt128;
      expect_blk("enc128_b2b", ct128, 11);
      wait_cf();

      // Inputs change while a block is in flight
      enc_dec = 1'b0; state_i = ct128;
      repeat (3) @(negedge CLK);
      state_i = junk; enc_dec = 1'b1;
      check("hold_state_o", state_o, ct128);
      expect_blk("midchange", pt128, 8);
      wait_cf();

      // CK mid-block: aborted block must never complete
      enc_dec = 1'b1; state_i = pt128;
      repeat (4) @(negedge CLK);
      pulse_ck();
      check("abort_state_o", state_o, pt128);
      check("abort_cf", 128'(CF), 128'd0);
      expect_blk("after_abort", ct128, 22);
      wait_cf();

      // KEY/KL changes without CK are ignored
      KEY[0] = 32'h00010203; KEY[1] = 32'h04050607; KEY[2] = 32'h08090A0B; KEY[3] = 32'h0C0D0E0F;
      KEY[4] = 32'h10111213; KEY[5] = 32'h14151617; KEY[6] = 32'h18191A1B; KEY[7] = 32'h1C1D1E1F;
      KL = 2'd2;
      expect_blk("key_ignored", ct128, 11);
      wait_cf();

      // AES-192
      KEY[6] = 32'h0; KEY[7] = 32'h0; KL = 2'd1; enc_dec = 1'b1; state_i = pt;
      pulse_ck();
      expect_blk("enc192", ct192, 26);
      wait_cf();
      enc_dec = 1'b0; state_i = ct192;
      expect_blk("dec192", pt, 13);
      wait_cf();

      // AES-256
      KEY[6] = 32'h18191A1B; KEY[7] = 32'h1C1D1E1F; KL = 2'd2; enc_dec = 1'b1; state_i = pt;
      pulse_ck();
      expect_blk("enc256", ct256, 29);
      wait_cf();
      enc_dec = 1'b0; state_i = ct256;
      expect_blk("dec256", pt, 15);
      wait_cf();

      // KL=3 behaves as 128-bit; upper key words are don't-care
      KEY[0] = 32'h54686174; KEY[1] = 32'h73206D79; KEY[2] = 32'h204B756E; KEY[3] = 32'h67204675;
      KEY[4] = 32'hDEADBEEF; KEY[5] = 32'hFEEDFACE; KEY[6] = 32'hA5A5A5A5; KEY[7] = 32'h5A5A5A5A;
      KL = 2'd3; enc_dec = 1'b1; state_i = pt128;
      pulse_ck();
      expect_blk("kl3", ct128, 22);
      wait_cf();

      // Async clear mid-round
      repeat (5) @(negedge CLK);
      CLR = 1'b1;
      #1;
      check("clr_state_o", state_o, '0);
      check("clr_cf", 128'(CF), 128'd0);
      @(negedge CLK);
      CLR = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
